// File: rtl/flt2fix_pkg.sv
// Shared definitions for the binary16 -> fixed-point converter.
//   state_t   : converter FSM states
//   constants : binary16 field geometry and fixed-point saturation limits
//   pivot()   : exponent at which the 11-bit significand needs no shift
package flt2fix_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  localparam int          EXP_BIAS = 15;
  localparam int          MANT_W   = 10;
  localparam int          EXP_MAX  = 31;
  localparam logic [15:0] FIX_MAX  = 16'h7FFF;
  localparam logic [15:0] FIX_MIN  = 16'h8000;

  // The significand {1,m} carries MANT_W fraction bits and the fixed-point
  // word carries frac_bits. An unshifted significand therefore lines up with
  // the fixed-point grid when e = EXP_BIAS + MANT_W - frac_bits.
  function automatic int pivot(input int frac_bits);
    return EXP_BIAS + MANT_W - frac_bits;
  endfunction

endpackage

// File: rtl/flt2fix_conv_unpack.sv
// Combinational binary16 field decode and shift planning.
//   flt_in       : binary16 operand
//   sign         : sign bit
//   is_zero      : zero or subnormal (flushes to 0)
//   is_special   : Inf or NaN
//   is_sat       : finite magnitude >= 2^15 (includes the exact minimum)
//   is_exact_min : -2^15 exactly, representable without saturation
//   shift_left   : 1 = shift significand left, 0 = right
//   shift_cnt    : number of one-bit shifts to perform
//   sig          : {1,m} zero-extended into the 16-bit working width
module flt16_unpack
  import flt2fix_pkg::*;
#(
  parameter int FRAC_BITS  = 8,
  parameter int MAX_RSHIFT = 11
) (
  input  logic [15:0] flt_in,
  output logic        sign,
  output logic        is_zero,
  output logic        is_special,
  output logic        is_sat,
  output logic        is_exact_min,
  output logic        shift_left,
  output logic [3:0]  shift_cnt,
  output logic [15:0] sig
);

  localparam logic [5:0] PIV     = 6'(pivot(FRAC_BITS));
  localparam logic [5:0] SAT_EXP = 6'(pivot(FRAC_BITS) + 5);
  localparam logic [5:0] RCAP    = 6'(MAX_RSHIFT);

  logic [5:0] exp6;
  logic [9:0] mant;
  logic [5:0] rdist;

  always_comb begin
    exp6         = {1'b0, flt_in[14:10]};
    mant         = flt_in[9:0];
    sign         = flt_in[15];
    sig          = {5'b0, 1'b1, mant};
    is_zero      = (exp6 == 6'd0);
    is_special   = (exp6 == 6'(EXP_MAX));
    is_sat       = !is_special && (exp6 >= SAT_EXP);
    is_exact_min = sign && (exp6 == SAT_EXP) && (mant == 10'd0);
    shift_left   = (exp6 >= PIV);
    rdist        = PIV - exp6;
    if (shift_left) begin
      shift_cnt = 4'(exp6 - PIV);
    end else if (rdist > RCAP) begin
      // Beyond the cap every significand bit has already fallen off.
      shift_cnt = 4'(RCAP);
    end else begin
      shift_cnt = 4'(rdist);
    end
  end

endmodule

// File: rtl/flt2fix_conv.sv
// Iterative binary16 -> signed Q(15-FRAC_BITS).FRAC_BITS converter.
//   Clk     : rising-edge clock
//   Reset   : asynchronous active-low reset
//   Start   : conversion request, honoured in IDLE or DONE
//   Flt_in  : binary16 operand, captured on the Start edge
//   Fix_out : signed fixed-point result, valid while Return=1
//   Return  : done level, held high in DONE
//   Sat     : result was saturated, valid while Return=1
// Specials (zero, Inf/NaN, out-of-range) finish on the Start edge. Normal
// operands shift one bit per cycle; the last shift moves straight to FIX and
// a zero-length shift skips SHIFT, so Return rises cnt+2 edges after Start.
module flt2fix_conv
  import flt2fix_pkg::*;
#(
  parameter int FRAC_BITS  = 8,
  parameter int MAX_RSHIFT = 11
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic        [15:0] Flt_in,
  output logic signed [15:0] Fix_out,
  output logic               Return,
  output logic               Sat
);

  state_t      state, state_nxt;
  logic [15:0] work;
  logic [3:0]  cnt;
  logic        sign_q, left_q;
  logic        load, shift_en, finish;

  logic        u_sign, u_zero, u_special, u_sat, u_exact_min, u_left;
  logic [3:0]  u_cnt;
  logic [15:0] u_sig;

  flt16_unpack #(
    .FRAC_BITS (FRAC_BITS),
    .MAX_RSHIFT(MAX_RSHIFT)
  ) u_unpack (
    .flt_in      (Flt_in),
    .sign        (u_sign),
    .is_zero     (u_zero),
    .is_special  (u_special),
    .is_sat      (u_sat),
    .is_exact_min(u_exact_min),
    .shift_left  (u_left),
    .shift_cnt   (u_cnt),
    .sig         (u_sig)
  );

  function automatic logic signed [15:0] sat_value(input logic s);
    return s ? signed'(FIX_MIN) : signed'(FIX_MAX);
  endfunction

  // Two's-complement negation also maps a -0 magnitude to 0.
  function automatic logic signed [15:0] apply_sign(input logic s, input logic [15:0] mag);
    logic signed [15:0] m_s;
    m_s = signed'(mag);
    return s ? -m_s : m_s;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          load = 1'b1;
          if (u_zero || u_special || u_sat) state_nxt = DONE;
          else if (u_cnt == 4'd0)           state_nxt = FIX;
          else                              state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt <= 4'd1) state_nxt = FIX;
      end
      FIX: begin
        finish    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      work    <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      left_q  <= 1'b0;
      Fix_out <= '0;
      Return  <= 1'b0;
      Sat     <= 1'b0;
    end else begin
      if (load) begin
        work   <= u_sig;
        cnt    <= u_cnt;
        sign_q <= u_sign;
        left_q <= u_left;
        if (u_zero) begin
          Fix_out <= '0;
          Sat     <= 1'b0;
          Return  <= 1'b1;
        end else if (u_special || u_sat) begin
          Fix_out <= sat_value(u_sign);
          Sat     <= u_special || !u_exact_min;
          Return  <= 1'b1;
        end else begin
          Return  <= 1'b0;
        end
      end
      if (shift_en) begin
        work <= left_q ? (work << 1) : (work >> 1);
        cnt  <= cnt - 4'd1;
      end
      if (finish) begin
        Fix_out <= apply_sign(sign_q, work);
        Sat     <= 1'b0;
        Return  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flt2fix_conv.sv
// Bench for flt2fix_conv (default 8.8 format): vector table, reset abort,
// back-to-back Start, and a sweep through an upstream fixed->float model.
module tb_flt2fix_conv;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Flt_in = 16'h0000;
  logic [15:0] Fix_out;
  logic        Return;
  logic        Sat;

  flt2fix_conv #(.FRAC_BITS(8), .MAX_RSHIFT(11)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Flt_in (Flt_in),
    .Fix_out(Fix_out),
    .Return (Return),
    .Sat    (Sat)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] flt;
    logic [15:0] fix;
    logic        sat;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] fix;
    logic        sat;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] flt, input logic [15:0] fix,
                              input logic sat, input int lat, input string name);
    vec_t v;
    v.flt = flt; v.fix = fix; v.sat = sat; v.lat = lat; v.name = name;
    return v;
  endfunction

  function automatic int msb_pos(input logic [15:0] mag);
    int k;
    k = 0;
    for (int b = 0; b < 16; b++) if (mag[b]) k = b;
    return k;
  endfunction

  // Upstream fixed(8.8)->binary16 stage: keeps the top 11 significant bits.
  function automatic logic [15:0] up16(input logic [15:0] x);
    logic [15:0] mag;
    logic [9:0]  m;
    int          k;
    if (x == 16'h0000) return 16'h0000;
    mag = x[15] ? (~x + 16'd1) : x;
    k   = msb_pos(mag);
    if (k >= 10) m = 10'(mag >> (k - 10));
    else         m = 10'(mag << (10 - k));
    return {x[15], 5'(k + 7), m};
  endfunction

  // x with the bits below the retained 11-bit significand cleared.
  function automatic logic [15:0] keep11(input logic [15:0] x);
    logic [15:0] mag;
    int          k;
    if (x == 16'h0000) return 16'h0000;
    mag = x[15] ? (~x + 16'd1) : x;
    k   = msb_pos(mag);
    if (k > 10) mag = mag & ~((16'd1 << (k - 10)) - 16'd1);
    return x[15] ? (~mag + 16'd1) : mag;
  endfunction

  function automatic int spec_lat(input logic [15:0] flt);
    int e;
    e = int'(flt[14:10]);
    if (e == 0 || e == 31 || e >= 22) return 1;
    if (e >= 17) return e - 17 + 2;
    return ((17 - e) > 11 ? 11 : (17 - e)) + 2;
  endfunction

  // Scoreboard consumer: a completion is Return rising, or Return staying
  // high across a Start edge (a special operand accepted from DONE).
  initial begin : monitor
    logic ret_q;
    logic st;
    exp_t e;
    ret_q = 1'b0;
    forever begin
      @(posedge Clk);
      st = Start;
      #1;
      edge_n++;
      if (!Reset) begin
        ret_q = 1'b0;
      end else begin
        if (Return === 1'b1 && (!ret_q || st)) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_return: got Return=1 at edge %0d want no pending result", edge_n);
          end else begin
            e = sb.pop_front();
            check({e.name, "_fix"}, 32'(Fix_out), 32'(e.fix));
            check({e.name, "_sat"}, 32'(Sat), 32'(e.sat));
            check({e.name, "_latency_edge"}, 32'(edge_n), 32'(e.due));
          end
        end
        ret_q = Return;
      end
    end
  end

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge Clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d results pending want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic apply(input logic [15:0] flt, input logic [15:0] fix, input logic sat,
                       input int lat, input string name);
    exp_t e;
    @(negedge Clk);
    Flt_in = flt;
    Start  = 1'b1;
    e.fix  = fix; e.sat = sat; e.due = edge_n + lat; e.name = name;
    sb.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
    wait_drain(name);
  endtask

  initial begin : main
    int          n0;
    logic [15:0] x;
    exp_t        e;

    tbl.push_back(mk(16'h3C00, 16'h0100, 1'b0,  4, "one"));
    tbl.push_back(mk(16'hBC00, 16'hFF00, 1'b0,  4, "neg_one"));
    tbl.push_back(mk(16'h3800, 16'h0080, 1'b0,  5, "half"));
    tbl.push_back(mk(16'h4400, 16'h0400, 1'b0,  2, "four_noshift"));
    tbl.push_back(mk(16'hC7FF, 16'hF801, 1'b0,  2, "neg_noshift"));
    tbl.push_back(mk(16'h57FF, 16'h7FF0, 1'b0,  6, "max_left"));
    tbl.push_back(mk(16'h4FFF, 16'h1FFC, 1'b0,  4, "rt_1fff"));
    tbl.push_back(mk(16'h1C00, 16'h0001, 1'b0, 12, "lsb"));
    tbl.push_back(mk(16'h1BFF, 16'h0000, 1'b0, 13, "rshift_cap"));
    tbl.push_back(mk(16'h5800, 16'h7FFF, 1'b1,  1, "sat_pos"));
    tbl.push_back(mk(16'hD800, 16'h8000, 1'b0,  1, "min_exact"));
    tbl.push_back(mk(16'hD801, 16'h8000, 1'b1,  1, "sat_neg"));
    tbl.push_back(mk(16'h7C00, 16'h7FFF, 1'b1,  1, "inf_pos"));
    tbl.push_back(mk(16'hFC00, 16'h8000, 1'b1,  1, "inf_neg"));
    tbl.push_back(mk(16'h7E00, 16'h7FFF, 1'b1,  1, "nan"));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0,  1, "zero"));
    tbl.push_back(mk(16'h8000, 16'h0000, 1'b0,  1, "neg_zero"));
    tbl.push_back(mk(16'h03FF, 16'h0000, 1'b0,  1, "subnormal"));

    repeat (3) @(negedge Clk);
    check("reset_fix", 32'(Fix_out), 32'h0);
    check("reset_return", 32'(Return), 32'h0);
    check("reset_sat", 32'(Sat), 32'h0);
    Reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i].flt, tbl[i].fix, tbl[i].sat, tbl[i].lat, tbl[i].name);

    // Reset aborting a conversion in flight.
    apply(16'h57FF, 16'h7FF0, 1'b0, 6, "pre_abort");
    @(negedge Clk);
    Flt_in = 16'h1C00;
    Start  = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_fix", 32'(Fix_out), 32'h0);
    check("abort_return", 32'(Return), 32'h0);
    check("abort_sat", 32'(Sat), 32'h0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (20) @(negedge Clk);
    check("abort_no_late_return", 32'(Return), 32'h0);
    apply(16'h3C00, 16'h0100, 1'b0, 4, "after_abort");

    // Start held high: two conversions, one-cycle Return pulse between them.
    @(negedge Clk);
    n0     = edge_n;
    Flt_in = 16'h3C00;
    Start  = 1'b1;
    e.fix = 16'h0100; e.sat = 1'b0; e.due = n0 + 4; e.name = "b2b_first";
    sb.push_back(e);
    e.fix = 16'hFF00; e.sat = 1'b0; e.due = n0 + 8; e.name = "b2b_second";
    sb.push_back(e);
    @(negedge Clk);
    Flt_in = 16'hBC00;
    while (edge_n < n0 + 5) @(negedge Clk);
    check("b2b_pulse_width", 32'(Return), 32'h0);
    Start = 1'b0;
    wait_drain("b2b");

    // Sweep through the upstream-equivalent model.
    for (int i = 0; i < 70; i++) begin
      case (i)
        0:       x = 16'h7FFF;
        1:       x = 16'h8000;
        2:       x = 16'h0001;
        3:       x = 16'hFFFF;
        4:       x = 16'h0000;
        5:       x = 16'h0800;
        default: x = 16'($urandom);
      endcase
      apply(up16(x), keep11(x), 1'b0, spec_lat(up16(x)), "sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
